fpdiv_arb: RTL and testbench
============================

FPDIV_ARB -- requirements
Module: fpdiv_arb

Interface
REQ-001 Parameter N_REQ, default 4, meaning number of requesters sharing one FP divider (2..8).
REQ-002 Parameter TIMEOUT, default 64, meaning cycles to wait for div_r_o before aborting (used only with FPDIV_ARB_TIMEOUT_EN).
REQ-003 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous, active-high.
REQ-005 Port req  in  N_REQ  per-requester request; held high with operands until that requester's ack.
REQ-006 Port n_bus  in  32*N_REQ  dividend per requester, slice i = bits [32i+31:32i], IEEE-754 single.
REQ-007 Port x_bus  in  32*N_REQ  divisor per requester, same slicing.
REQ-008 Port ack  out  N_REQ  one-cycle completion pulse to the served requester.
REQ-009 Port err  out  N_REQ  one-cycle timeout flag, coincident with ack.
REQ-010 Port res  out  32  result, valid in the ack cycle and held until the next ack.
REQ-011 Port busy  out  1  high while a division is in flight (states BUSY and DONE).
REQ-012 Port div_n, div_x  out  32 each  operands to the divider, registered.
REQ-013 Port div_r_i  out  1  start request to the divider.
REQ-014 Port div_res  in  32; Port div_r_o  in  1  divider result and one-cycle done pulse.

Function
REQ-015 FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-016 IDLE: if any req bit is 1, grant the first requester at or after rr_ptr (wrapping mod N_REQ), latch its n/x slices into div_n/div_x, set div_r_i=1, go BUSY; else stay in IDLE.
REQ-017 rr_ptr is set to (granted index + 1) mod N_REQ at the grant edge; reset value 0.
REQ-018 BUSY: div_r_i stays 1 until the edge at which div_r_o is sampled 1; at that edge div_r_i is cleared, res is latched from div_res, and the FSM goes to DONE.
REQ-019 DONE: ack[grant]=1 for exactly one cycle; the FSM then goes to IDLE.
REQ-020 Latency: grant edge to div_r_i high is 0 cycles (same edge); div_r_o sample to ack is 1 cycle.
REQ-021 req bits sampled in BUSY or DONE are ignored; a req still high in the cycle after ack is treated as a new request.
REQ-022 div_r_o sampled in IDLE or DONE is ignored; it covers a stray completion after reset.
REQ-023 With several simultaneous requests, exactly one is granted per operation, and no requester waits more than N_REQ−1 other grants.
REQ-024 div_n/div_x stay constant from the grant edge until the next grant.
REQ-025 At most one ack bit is high in any cycle; err is never high without the matching ack bit.

Reset
REQ-026 rst=1 forces IDLE asynchronously and clears rr_ptr=0, ack=0, err=0, res=0, div_n=0, div_x=0, div_r_i=0, busy=0, and the timeout counter to 0.
REQ-027 If rst is asserted mid-operation, no ack is generated for the aborted request; the requester must keep req high to be re-served.

Configuration
REQ-028 Macro FPDIV_ARB_TIMEOUT_EN defined: a 16-bit counter clears at the grant edge and increments each BUSY cycle; on reaching TIMEOUT it clears div_r_i, sets res=32'h7FC00000, goes to DONE, and asserts err[grant] together with ack.
REQ-029 Macro not defined: no counter is built, err is tied to 0, and BUSY waits for div_r_o indefinitely.

Structure
REQ-030 Package fpdiv_arb_pkg holds the state enum (IDLE, BUSY, DONE), the QNAN constant 32'h7FC00000 and the counter width constant.
REQ-031 Sub-module rr_pick (combinational round-robin picker: req, rr_ptr -> one-hot grant plus index) is instantiated once.

Verification
REQ-032 Single request, req[0], n=0x40C00000 (6.0), x=0x40000000 (2.0) -> div_r_i rises at the grant edge; ack[0] pulses 1 cycle after div_r_o; res=0x40400000.
REQ-033 req=4'b1111 held continuously from reset -> grant order 0,1,2,3,0; each ack is a single pulse; busy stays high across each operation.
REQ-034 rr_ptr=2 with req=4'b0011 -> requester 0 is granted first, then requester 1.
REQ-035 rst pulsed during BUSY -> all outputs return to reset values immediately; the later stray div_r_o pulse produces no ack.
REQ-036 With FPDIV_ARB_TIMEOUT_EN, TIMEOUT=8 and a divider model that never asserts div_r_o -> ack[g] and err[g] pulse together 8 BUSY cycles after the grant; res=0x7FC00000.
REQ-037 Requester 1 keeps req high after its ack and requester 2 is also requesting -> requester 2 is granted next.

Source files
------------

// File: rtl/fpdiv_arb_pkg.sv
// Shared types and constants for the FP-divider round-robin arbiter.
package fpdiv_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam int unsigned CNT_W = 16;

endpackage

// File: rtl/fpdiv_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping mod N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDXW  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDXW-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDXW-1:0]  idx,
    output logic             valid
);

    int unsigned w_p;

    // Outer loop walks rotational distance from ptr so the nearest requester wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        w_p   = 32'(ptr);
        for (int unsigned d = 0; d < N_REQ; d++) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                if (!valid && req[i] && (((i + N_REQ - w_p) % N_REQ) == d)) begin
                    valid  = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = IDXW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fpdiv_arb.sv
// Round-robin arbiter sharing one FP divider among N_REQ requesters.
// Optional divider timeout enabled by defining FPDIV_ARB_TIMEOUT_EN.
module fpdiv_arb #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  n_bus,
    input  logic [32*N_REQ-1:0]  x_bus,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     err,
    output logic [31:0]          res,
    output logic                 busy,
    output logic [31:0]          div_n,
    output logic [31:0]          div_x,
    output logic                 div_r_i,
    input  logic [31:0]          div_res,
    input  logic                 div_r_o
);
    import fpdiv_arb_pkg::*;

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             r_state;
    logic [IDXW-1:0]    r_ptr;
    logic [N_REQ-1:0]   r_gnt;
    logic [N_REQ-1:0]   r_ack;
    logic [31:0]        r_res;
    logic [31:0]        r_div_n;
    logic [31:0]        r_div_x;
    logic               r_div_r_i;
    logic               r_busy;

    logic [N_REQ-1:0]   w_gnt;
    logic [IDXW-1:0]    w_idx;
    logic               w_valid;
    logic [31:0]        w_n;
    logic [31:0]        w_x;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDXW  (IDXW)
    ) u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .gnt   (w_gnt),
        .idx   (w_idx),
        .valid (w_valid)
    );

    always_comb begin
        w_n = '0;
        w_x = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_n |= n_bus[32*i +: 32] & {32{w_gnt[i]}};
            w_x |= x_bus[32*i +: 32] & {32{w_gnt[i]}};
        end
    end

`ifdef FPDIV_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [N_REQ-1:0]   r_err;

    assign w_cnt_nxt = r_cnt + 1'b1;
    assign err       = r_err;
`else
    assign err       = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_ack     <= '0;
            r_res     <= '0;
            r_div_n   <= '0;
            r_div_x   <= '0;
            r_div_r_i <= 1'b0;
            r_busy    <= 1'b0;
`ifdef FPDIV_ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_err     <= '0;
`endif
        end else begin
            r_ack <= '0;
`ifdef FPDIV_ARB_TIMEOUT_EN
            r_err <= '0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_state   <= BUSY;
                        r_gnt     <= w_gnt;
                        r_ptr     <= (w_idx == IDXW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
                        r_div_n   <= w_n;
                        r_div_x   <= w_x;
                        r_div_r_i <= 1'b1;
                        r_busy    <= 1'b1;
`ifdef FPDIV_ARB_TIMEOUT_EN
                        r_cnt     <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (div_r_o) begin
                        r_div_r_i <= 1'b0;
                        r_res     <= div_res;
                        r_ack     <= r_gnt;
                        r_state   <= DONE;
                    end
`ifdef FPDIV_ARB_TIMEOUT_EN
                    else if (w_cnt_nxt == CNT_W'(TIMEOUT)) begin
                        r_cnt     <= w_cnt_nxt;
                        r_div_r_i <= 1'b0;
                        r_res     <= QNAN;
                        r_ack     <= r_gnt;
                        r_err     <= r_gnt;
                        r_state   <= DONE;
                    end else begin
                        r_cnt     <= w_cnt_nxt;
                    end
`endif
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack     = r_ack;
    assign res     = r_res;
    assign busy    = r_busy;
    assign div_n   = r_div_n;
    assign div_x   = r_div_x;
    assign div_r_i = r_div_r_i;

endmodule

// File: tb/tb_fpdiv_arb.sv
// Directed bench for fpdiv_arb: arbitration order, handshake timing, reset abort, timeout.
module tb_fpdiv_arb;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] n_bus;
    logic [127:0] x_bus;
    logic [3:0]   ack;
    logic [3:0]   err;
    logic [31:0]  res;
    logic         busy;
    logic [31:0]  div_n;
    logic [31:0]  div_x;
    logic         div_r_i;
    logic [31:0]  div_res;
    logic         div_r_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] n;
        logic [31:0] x;
        logic [31:0] q;
        int unsigned lat;
        int unsigned g;
    } vec_t;

    vec_t vt [12];

    fpdiv_arb #(
        .N_REQ   (4),
        .TIMEOUT (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .n_bus   (n_bus),
        .x_bus   (x_bus),
        .ack     (ack),
        .err     (err),
        .res     (res),
        .busy    (busy),
        .div_n   (div_n),
        .div_x   (div_x),
        .div_r_i (div_r_i),
        .div_res (div_res),
        .div_r_o (div_r_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Each requester's operands differ in the low bits so the granted slice is identifiable.
    task automatic load_ops(input logic [31:0] n, input logic [31:0] x);
        for (int i = 0; i < 4; i++) begin
            n_bus[32*i +: 32] = n ^ 32'(i);
            x_bus[32*i +: 32] = x ^ 32'(i << 4);
        end
    endtask

    // Called inside an IDLE cycle; the next rising edge is the grant edge.
    task automatic run_vec(input vec_t v, input int k);
        logic [31:0] en;
        logic [31:0] ex;
        logic [3:0]  oh;
        en = v.n ^ 32'(v.g);
        ex = v.x ^ 32'(v.g << 4);
        oh = 4'(1 << v.g);
        req = v.req;
        load_ops(v.n, v.x);
        @(posedge clk); #1;
        check($sformatf("v%0d div_r_i@grant", k), 32'(div_r_i), 32'd1);
        check($sformatf("v%0d busy@grant", k), 32'(busy), 32'd1);
        check($sformatf("v%0d div_n", k), div_n, en);
        check($sformatf("v%0d div_x", k), div_x, ex);
        check($sformatf("v%0d ack@grant", k), 32'(ack), 32'd0);
        repeat (v.lat) @(posedge clk);
        @(negedge clk);
        check($sformatf("v%0d div_r_i held", k), 32'(div_r_i), 32'd1);
        div_r_o = 1'b1;
        div_res = v.q;
        @(posedge clk); #1;
        div_r_o = 1'b0;
        div_res = 32'hDEAD_BEEF;
        check($sformatf("v%0d ack", k), 32'(ack), 32'(oh));
        check($sformatf("v%0d err", k), 32'(err), 32'd0);
        check($sformatf("v%0d res", k), res, v.q);
        check($sformatf("v%0d div_r_i@done", k), 32'(div_r_i), 32'd0);
        check($sformatf("v%0d busy@done", k), 32'(busy), 32'd1);
        check($sformatf("v%0d div_n@done", k), div_n, en);
        @(posedge clk); #1;
        check($sformatf("v%0d ack cleared", k), 32'(ack), 32'd0);
        check($sformatf("v%0d busy cleared", k), 32'(busy), 32'd0);
        check($sformatf("v%0d res held", k), res, v.q);
    endtask

    initial begin
        vt[0]  = '{4'b1111, 32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 0, 0};
        vt[1]  = '{4'b1111, 32'h4120_0000, 32'h40A0_0000, 32'h4000_0000, 1, 1};
        vt[2]  = '{4'b1111, 32'h4100_0000, 32'h4080_0000, 32'h4000_0000, 0, 2};
        vt[3]  = '{4'b1111, 32'h4040_0000, 32'h3F80_0000, 32'h4040_0000, 2, 3};
        vt[4]  = '{4'b1111, 32'h4200_0000, 32'h4100_0000, 32'h4080_0000, 0, 0};
        vt[5]  = '{4'b0001, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 3, 0};
        vt[6]  = '{4'b0110, 32'h4180_0000, 32'h4080_0000, 32'h4080_0000, 1, 1};
        vt[7]  = '{4'b0110, 32'h4220_0000, 32'h4120_0000, 32'h4080_0000, 0, 2};
        vt[8]  = '{4'b0010, 32'h3F00_0000, 32'h3F80_0000, 32'h3F00_0000, 0, 1};
        vt[9]  = '{4'b0011, 32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 2, 0};
        vt[10] = '{4'b0011, 32'h4160_0000, 32'h40E0_0000, 32'h4000_0000, 0, 1};
        vt[11] = '{4'b1000, 32'h4280_0000, 32'h4180_0000, 32'h4080_0000, 5, 3};

        rst     = 1'b1;
        req     = vt[0].req;
        div_r_o = 1'b0;
        div_res = 32'h0;
        load_ops(vt[0].n, vt[0].x);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ack", 32'(ack), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset res", res, 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset div_r_i", 32'(div_r_i), 32'd0);
        check("reset div_n", div_n, 32'd0);
        check("reset div_x", div_x, 32'd0);
        rst = 1'b0;

        for (int k = 0; k < 12; k++) run_vec(vt[k], k);

        // Abort an operation with reset, then feed a stray completion pulse.
        req = 4'b0100;
        load_ops(32'h4300_0000, 32'h4200_0000);
        @(posedge clk); #1;
        check("abort granted", 32'(div_r_i), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort ack", 32'(ack), 32'd0);
        check("abort err", 32'(err), 32'd0);
        check("abort res", res, 32'd0);
        check("abort div_n", div_n, 32'd0);
        check("abort div_x", div_x, 32'd0);
        check("abort div_r_i", 32'(div_r_i), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        req = 4'b0000;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        div_r_o = 1'b1;
        div_res = 32'h1234_5678;
        @(negedge clk);
        div_r_o = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check($sformatf("stray ack c%0d", k), 32'(ack), 32'd0);
            check($sformatf("stray busy c%0d", k), 32'(busy), 32'd0);
        end
        check("stray res", res, 32'd0);

        req = 4'b0001;
        load_ops(32'h4000_0000, 32'h0000_0000);
        @(posedge clk); #1;
        check("to grant", 32'(div_r_i), 32'd1);
`ifdef FPDIV_ARB_TIMEOUT_EN
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            check($sformatf("to wait c%0d", k), 32'(ack), 32'd0);
        end
        @(posedge clk); #1;
        check("to ack", 32'(ack), 32'd1);
        check("to err", 32'(err), 32'd1);
        check("to res", res, 32'h7FC0_0000);
        check("to div_r_i", 32'(div_r_i), 32'd0);
        req = 4'b0000;
        @(posedge clk); #1;
        check("to ack cleared", 32'(ack), 32'd0);
        check("to err cleared", 32'(err), 32'd0);
`else
        repeat (20) @(posedge clk);
        #1;
        check("nto no ack", 32'(ack), 32'd0);
        check("nto busy", 32'(busy), 32'd1);
        check("nto div_r_i", 32'(div_r_i), 32'd1);
        @(negedge clk);
        div_r_o = 1'b1;
        div_res = 32'h7F80_0000;
        @(posedge clk); #1;
        div_r_o = 1'b0;
        req     = 4'b0000;
        check("nto ack", 32'(ack), 32'd1);
        check("nto err", 32'(err), 32'd0);
        check("nto res", res, 32'h7F80_0000);
        @(posedge clk); #1;
        check("nto ack cleared", 32'(ack), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
